compare_match_unit: RTL and testbench

//  Downstream consumer of the free-running N-bit counter's cnt output. Compares cnt against a

---
 rtl/compare_pkg.sv | 11 +
 rtl/compare_match_unit.sv | 118 +++++++++++
 tb/tb_compare_match_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/compare_pkg.sv
// Shared types for the compare/match unit.
//   match_state_t : FSM encoding (IDLE, ARMED, FIRED)
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } match_state_t;

endpackage

// File: rtl/compare_match_unit.sv
// compare_match_unit
//   Compares the free-running counter value against a double-buffered compare
//   register. Produces a registered match pulse, a PWM level and a sticky
//   interrupt flag with overrun detection. New compare values enter through a
//   valid/ready handshake into a one-deep pending buffer and are promoted to the
//   active register only at the counter wrap (cnt == all ones).
// Ports
//   clock, reset            : rising-edge clock, async active-high reset
//   cnt                     : counter value (same clock domain)
//   cmp_valid/cmp_data/cmp_ready : compare value handshake
//   one_shot, arm, disarm   : FSM control
//   match_pulse             : one-cycle pulse, one cycle after a match
//   pwm_out                 : registered (cnt < active compare)
//   irq_flag, overrun       : sticky flags, cleared by irq_clear
module compare_match_unit
    import compare_pkg::*;
#(
    parameter int N = 8,
    parameter logic [N-1:0] CMP_RESET = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] cnt,
    input  logic         cmp_valid,
    input  logic [N-1:0] cmp_data,
    output logic         cmp_ready,
    input  logic         one_shot,
    input  logic         arm,
    input  logic         disarm,
    output logic         match_pulse,
    output logic         pwm_out,
    output logic         irq_flag,
    input  logic         irq_clear,
    output logic         overrun
);

    logic         r_pending;
    logic [N-1:0] r_pending_data;
    logic [N-1:0] r_active_cmp;
    match_state_t r_state;
    logic         r_match_pulse;
    logic         r_pwm;
    logic         r_irq;
    logic         r_overrun;

    logic w_boundary;
    logic w_xfer;
    logic w_match;

    assign w_boundary = (cnt == {N{1'b1}});
    assign w_xfer     = cmp_valid && !r_pending;
    // disarm suppresses a coincident match entirely
    assign w_match    = (r_state == ARMED) && (cnt == r_active_cmp) && !disarm;

    // Double buffer. A transfer in a boundary cycle can only happen when the
    // buffer was empty, so it lands in pending and waits a full period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending      <= 1'b0;
            r_pending_data <= '0;
            r_active_cmp   <= CMP_RESET;
        end else if (w_boundary && r_pending) begin
            r_active_cmp <= r_pending_data;
            r_pending    <= 1'b0;
        end else if (w_xfer) begin
            r_pending_data <= cmp_data;
            r_pending      <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (disarm) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (arm) r_state <= ARMED;
                ARMED:   if (w_match && one_shot) r_state <= FIRED;
                FIRED:   if (arm) r_state <= ARMED;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (cnt < r_active_cmp);
        end
    end

    // A new match beats irq_clear: the flag stays set, overrun restarts at 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_match_pulse <= 1'b0;
            r_irq         <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_match_pulse <= w_match;
            if (w_match) begin
                r_irq     <= 1'b1;
                r_overrun <= irq_clear ? 1'b0 : (r_overrun | r_irq);
            end else if (irq_clear) begin
                r_irq     <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign cmp_ready   = !r_pending;
    assign match_pulse = r_match_pulse;
    assign pwm_out     = r_pwm;
    assign irq_flag    = r_irq;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_compare_match_unit.sv
module tb_compare_match_unit;

    localparam int N = 2;
    localparam logic [N-1:0] CMP_RST = 2'd1;
    localparam int TOP = (1 << N) - 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] cnt;
    logic         cmp_valid = 1'b0;
    logic [N-1:0] cmp_data = '0;
    logic         cmp_ready;
    logic         one_shot = 1'b0;
    logic         arm = 1'b0;
    logic         disarm = 1'b0;
    logic         match_pulse;
    logic         pwm_out;
    logic         irq_flag;
    logic         irq_clear = 1'b0;
    logic         overrun;

    int n_chk = 0;
    int n_fail = 0;
    int n_pulse = 0;
    int n_pwm = 0;

    // behavioural model (state: 0 idle, 1 armed, 2 fired)
    int m_pend, m_pdata, m_act, m_st, m_pulse, m_pwm, m_irq, m_ovr;

    compare_match_unit #(.N(N), .CMP_RESET(CMP_RST)) dut (
        .clock(clock), .reset(reset), .cnt(cnt),
        .cmp_valid(cmp_valid), .cmp_data(cmp_data), .cmp_ready(cmp_ready),
        .one_shot(one_shot), .arm(arm), .disarm(disarm),
        .match_pulse(match_pulse), .pwm_out(pwm_out), .irq_flag(irq_flag),
        .irq_clear(irq_clear), .overrun(overrun)
    );

    always #50 clock = ~clock;

    // free-running counter feeding cnt
    always @(posedge clock or posedge reset)
        if (reset) cnt <= '0;
        else       cnt <= cnt + 1'b1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pend = 0; m_pdata = 0; m_act = int'(CMP_RST); m_st = 0;
        m_pulse = 0; m_pwm = 0; m_irq = 0; m_ovr = 0;
    endtask

    task automatic chk_outs(input string pfx);
        chk({pfx, ".pulse"}, int'(match_pulse), m_pulse);
        chk({pfx, ".pwm"},   int'(pwm_out),     m_pwm);
        chk({pfx, ".irq"},   int'(irq_flag),    m_irq);
        chk({pfx, ".ovr"},   int'(overrun),     m_ovr);
        chk({pfx, ".rdy"},   int'(cmp_ready),   m_pend ? 0 : 1);
    endtask

    // One clock: derive next model state from the rules, take the edge, compare.
    task automatic cycle();
        int c, hit, n_act, n_pend, n_pdata, n_st, n_irq, n_ovr;
        c = int'(cnt);
        hit = (m_st == 1 && c == m_act && !disarm) ? 1 : 0;
        n_act = m_act; n_pend = m_pend; n_pdata = m_pdata;
        if (c == TOP && m_pend) begin
            n_act = m_pdata; n_pend = 0;
        end else if (cmp_valid && !m_pend) begin
            n_pend = 1; n_pdata = int'(cmp_data);
        end
        n_st = m_st;
        if (disarm)                    n_st = 0;
        else if (m_st != 1 && arm)     n_st = 1;
        else if (hit && one_shot)      n_st = 2;
        n_irq = m_irq; n_ovr = m_ovr;
        if (hit) begin
            n_ovr = irq_clear ? 0 : (m_ovr | m_irq);
            n_irq = 1;
        end else if (irq_clear) begin
            n_irq = 0; n_ovr = 0;
        end
        @(posedge clock);
        m_pwm = (c < m_act) ? 1 : 0;
        m_pulse = hit;
        m_act = n_act; m_pend = n_pend; m_pdata = n_pdata;
        m_st = n_st; m_irq = n_irq; m_ovr = n_ovr;
        #1;
        chk_outs("cyc");
        n_pulse += int'(match_pulse);
        n_pwm   += int'(pwm_out);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_in(input int which);
        case (which)
            0: arm = 1'b1;
            1: disarm = 1'b1;
            default: irq_clear = 1'b1;
        endcase
        cycle();
        arm = 1'b0; disarm = 1'b0; irq_clear = 1'b0;
    endtask

    task automatic load(input int v);
        cmp_data = N'(v); cmp_valid = 1'b1;
        cycle();
        cmp_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int k;
        k = 0;
        while (int'(cnt) != v && k < 8) begin cycle(); k++; end
        chk("wait_cnt_bound", (k < 8) ? 1 : 0, 1);
    endtask

    initial begin
        bit fire, done;
        m_reset();
        // 1. reset values
        #120;
        chk_outs("rst");
        chk("rst.pulse0", int'(match_pulse), 0);
        chk("rst.rdy1", int'(cmp_ready), 1);
        reset = 1'b0;

        // 2. load 2, continuous mode
        one_shot = 1'b0;
        load(2);
        chk("t2.rdy_busy", int'(cmp_ready), 0);
        pulse_in(0);
        run(4);
        n_pulse = 0; n_pwm = 0;
        run(8);
        chk("t2.pulses", n_pulse, 2);
        chk("t2.pwm_hi", n_pwm, 4);

        // 3. second value held while first is pending
        load(1);
        chk("t3.rdy0", int'(cmp_ready), 0);
        cmp_data = 2'd3; cmp_valid = 1'b1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            fire = cmp_ready;
            cycle();
            if (fire) begin cmp_valid = 1'b0; done = 1; end
        end
        chk("t3.accept", int'(done), 1);
        cmp_valid = 1'b0;
        run(10);

        // 4. one-shot at cmp 0
        pulse_in(1);
        pulse_in(2);
        one_shot = 1'b1;
        load(0);
        run(5);
        pulse_in(0);
        n_pulse = 0;
        run(8);
        chk("t4.one", n_pulse, 1);
        pulse_in(0);
        n_pulse = 0;
        run(4);
        chk("t4.rearm", n_pulse, 1);

        // 5. irq / overrun
        one_shot = 1'b0;
        pulse_in(0);
        run(8);
        chk("t5.irq", int'(irq_flag), 1);
        chk("t5.ovr", int'(overrun), 1);
        wait_cnt(1);
        pulse_in(2);
        chk("t5.clr_irq", int'(irq_flag), 0);
        chk("t5.clr_ovr", int'(overrun), 0);
        wait_cnt(0);
        cycle();
        wait_cnt(0);
        pulse_in(2);
        chk("t5.win_irq", int'(irq_flag), 1);
        chk("t5.win_ovr", int'(overrun), 0);

        // 6. async reset while pending and armed
        load(2);
        chk("t6.pend", int'(cmp_ready), 0);
        #20 reset = 1'b1;
        #5;
        m_reset();
        chk_outs("t6.async");
        @(posedge clock); #1;
        chk_outs("t6.held");
        #10 reset = 1'b0;
        n_pulse = 0;
        run(8);
        chk("t6.nomatch", n_pulse, 0);
        arm = 1'b1; disarm = 1'b1;
        cycle();
        arm = 1'b0; disarm = 1'b0;
        n_pulse = 0;
        run(8);
        chk("t6.armdis", n_pulse, 0);

        // random phase
        for (int i = 0; i < 400; i++) begin
            cmp_valid = ($urandom_range(0, 3) == 0);
            cmp_data  = N'($urandom);
            arm       = ($urandom_range(0, 5) == 0);
            disarm    = ($urandom_range(0, 15) == 0);
            irq_clear = ($urandom_range(0, 7) == 0);
            one_shot  = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
